seg_scan_decoder: RTL and testbench

//  Receive end of the multiplexed 4-digit 7-segment bus that the display driver produces (AN, SEGMENT).

---
 rtl/seg_scan_pkg.sv | 38 +++
 rtl/seg7_decode.sv | 42 ++++
 rtl/seg_scan_decoder.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan decoder: digit-select codes, FSM states
// and segment patterns, written MSB-first as {a,b,c,d,e,f,g} with 1 = segment off.
package seg_scan_pkg;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  localparam logic [6:0] PAT_0     = 7'b0000001;
  localparam logic [6:0] PAT_1     = 7'b1001111;
  localparam logic [6:0] PAT_2     = 7'b0010010;
  localparam logic [6:0] PAT_3     = 7'b0000110;
  localparam logic [6:0] PAT_4     = 7'b1001100;
  localparam logic [6:0] PAT_5     = 7'b0100100;
  localparam logic [6:0] PAT_6     = 7'b0100000;
  localparam logic [6:0] PAT_7     = 7'b0001111;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0000100;
  localparam logic [6:0] PAT_A     = 7'b0001000;
  localparam logic [6:0] PAT_B     = 7'b1100000;
  localparam logic [6:0] PAT_C     = 7'b0110001;
  localparam logic [6:0] PAT_D     = 7'b1000010;
  localparam logic [6:0] PAT_E     = 7'b0110000;
  localparam logic [6:0] PAT_F     = 7'b0111000;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  // The bus carries a in bit 0 and g in bit 6; the pattern table is a-first.
  function automatic logic [6:0] to_abcdefg(input logic [6:0] seg);
    return {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6]};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low 7-segment pattern to hex nibble decoder; flags blank
// (all segments off) and unrecognised patterns.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       blank,
  output logic       err
);

  logic [6:0] abcdefg;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    abcdefg = to_abcdefg(seg);
    hex     = 4'h0;
    blank   = 1'b0;
    err     = 1'b0;
    case (abcdefg)
      PAT_0:     hex = 4'h0;
      PAT_1:     hex = 4'h1;
      PAT_2:     hex = 4'h2;
      PAT_3:     hex = 4'h3;
      PAT_4:     hex = 4'h4;
      PAT_5:     hex = 4'h5;
      PAT_6:     hex = 4'h6;
      PAT_7:     hex = 4'h7;
      PAT_8:     hex = 4'h8;
      PAT_9:     hex = 4'h9;
      PAT_A:     hex = 4'hA;
      PAT_B:     hex = 4'hB;
      PAT_C:     hex = 4'hC;
      PAT_D:     hex = 4'hD;
      PAT_E:     hex = 4'hE;
      PAT_F:     hex = 4'hF;
      PAT_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a scanned 4-digit 7-segment bus: synchronise, wait for stable digit
// dwells, decode and reassemble whole frames. Frame timeout built with SEG_SCAN_TIMEOUT_EN.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        frame_valid,
  output logic [3:0]  decode_err,
  output logic        frame_tmo
);

  localparam int CNT_MAX = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;

  if (CNT_W < $clog2(CNT_MAX + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for STABLE_CYCLES/TIMEOUT_CYCLES");
  end

  logic [3:0]       an_meta, an_sync;
  logic [7:0]       seg_meta, seg_sync;
  logic [11:0]      prev;
  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             an_valid, changed, accept;
  logic [3:0]       sel;
  logic [3:0]       dec_hex;
  logic             dec_blank, dec_err;
  logic [3:0]       seen, seen_next;
  logic [15:0]      sh_hexs;
  logic [3:0]       sh_points, sh_les;
  logic             commit, tmr_hit, tmo;

  assign an_valid = an_sync inside {AN_D0, AN_D1, AN_D2, AN_D3};
  assign changed  = ({an_sync, seg_sync} != prev);
  assign sel      = ~an_sync;
  assign commit   = (seen == 4'hF);

  seg7_decode u_decode (
    .seg   (seg_sync[6:0]),
    .hex   (dec_hex),
    .blank (dec_blank),
    .err   (dec_err)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    case (state)
      SETTLE: begin
        if (!an_valid || changed) begin
          count_next = '0;
        end else if (count == CNT_W'(STABLE_CYCLES - 1)) begin
          accept     = 1'b1;
          count_next = '0;
          state_next = HOLD;
        end else begin
          count_next = count + 1'b1;
        end
      end
      HOLD: begin
        if (changed) begin
          count_next = '0;
          state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // A commit outranks a timeout; an acceptance in the same cycle starts the next frame.
  always_comb begin
    seen_next = seen;
    tmo       = 1'b0;
    if (commit) begin
      seen_next = '0;
    end else if (tmr_hit) begin
      seen_next = '0;
      tmo       = 1'b1;
    end
    if (accept) seen_next = seen_next | sel;
  end

`ifdef SEG_SCAN_TIMEOUT_EN
  logic [CNT_W-1:0] tmr;

  assign tmr_hit = (seen != 4'h0) && (tmr == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || seen == 4'h0 || commit || tmr_hit) tmr <= '0;
    else                                          tmr <= tmr + 1'b1;
  end
`else
  assign tmr_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      an_meta  <= 4'hF;
      an_sync  <= 4'hF;
      seg_meta <= 8'hFF;
      seg_sync <= 8'hFF;
      prev     <= 12'hFFF;
      state    <= SETTLE;
      count    <= '0;
      seen     <= '0;
    end else begin
      an_meta  <= AN;
      an_sync  <= an_meta;
      seg_meta <= SEGMENT;
      seg_sync <= seg_meta;
      prev     <= {an_sync, seg_sync};
      state    <= state_next;
      count    <= count_next;
      seen     <= seen_next;
    end
  end

  // NOTE: the shadow frame has no reset; seen decides when its contents are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept && sel[i]) begin
        sh_hexs[4*i +: 4] <= dec_hex;
        sh_points[i]      <= seg_sync[7];
        sh_les[i]         <= dec_blank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hexs        <= '0;
      points      <= '0;
      LEs         <= 4'hF;
      frame_valid <= 1'b0;
      decode_err  <= '0;
      frame_tmo   <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_tmo   <= tmo;
      decode_err  <= decode_err | ({4{accept & dec_err}} & sel);
      if (commit) begin
        hexs   <= sh_hexs;
        points <= sh_points;
        LEs    <= sh_les;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed frames then random dwells scored
// cycle by cycle against a dwell-level reference model.
module tb_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int ACC_AT  = STABLE + 2;  // dwell step at which an acceptance becomes visible
  localparam int MIN_ACC = STABLE + 4;  // shortest dwell that also shows its own commit
`ifdef SEG_SCAN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Active-low bus encodings SEGMENT[6:0] for hex digits 0..F.
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  AN = 4'hF;
  logic [7:0]  SEGMENT = 8'hFF;
  logic [15:0] hexs;
  logic [3:0]  points, LEs, decode_err;
  logic        frame_valid, frame_tmo;

  seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .AN          (AN),
    .SEGMENT     (SEGMENT),
    .hexs        (hexs),
    .points      (points),
    .LEs         (LEs),
    .frame_valid (frame_valid),
    .decode_err  (decode_err),
    .frame_tmo   (frame_tmo)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_cnt   = 0, fv_cyc = -1;
  int tmo_cnt  = 0, tmo_cyc = -1;
  int last_start = 0;
  logic [11:0] last_key = 12'hFFF;

  // Reference model state
  logic [15:0] m_hexs = '0;
  logic [3:0]  m_points = '0, m_les = 4'hF, m_err = '0, m_seen = '0;
  logic        m_fv = 1'b0, m_tmo = 1'b0;
  logic [3:0]  s_hex [4];
  logic        s_pt [4];
  logic        s_le [4];
  int          m_t0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expd, cyc);
    end
  endtask

  function automatic int dig(input logic [3:0] an);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      pat = 4'hF;
      pat[i] = 1'b0;
      if (an == pat) return i;
    end
    return -1;
  endfunction

  function automatic void model_decode(input logic [6:0] s, output logic [3:0] h,
                                       output logic bl, output logic er);
    h  = 4'h0;
    bl = 1'b0;
    er = 1'b0;
    if (s == 7'h7F) bl = 1'b1;
    else begin
      er = 1'b1;
      for (int i = 0; i < 16; i++)
        if (s == SEG_TBL[i]) begin
          h  = 4'(i);
          er = 1'b0;
        end
    end
  endfunction

  // One clock: drive, advance model to the post-edge state, then score all outputs.
  task automatic step(input logic [3:0] an, input logic [7:0] seg, input bit acc);
    int n;
    logic [3:0] h;
    logic bl, er;
    AN = an;
    SEGMENT = seg;
    @(posedge clk);
    cyc++;
    m_fv  = 1'b0;
    m_tmo = 1'b0;
    if (rst) begin
      m_hexs = '0; m_points = '0; m_les = 4'hF; m_err = '0; m_seen = '0;
    end else begin
      if (m_seen == 4'hF) begin
        for (int i = 0; i < 4; i++) begin
          m_hexs[4*i +: 4] = s_hex[i];
          m_points[i] = s_pt[i];
          m_les[i] = s_le[i];
        end
        m_fv = 1'b1;
        m_seen = '0;
      end else if (TMO_EN && m_seen != 4'h0 && cyc == m_t0 + TIMEOUT) begin
        m_tmo = 1'b1;
        m_seen = '0;
      end
      if (acc) begin
        n = dig(an);
        model_decode(seg[6:0], h, bl, er);
        if (m_seen == 4'h0) m_t0 = cyc;
        s_hex[n] = h;
        s_pt[n] = seg[7];
        s_le[n] = bl;
        m_seen[n] = 1'b1;
        if (er) m_err[n] = 1'b1;
      end
    end
    #1;
    if (frame_valid === 1'b1) begin fv_cnt++;  fv_cyc = cyc;  end
    if (frame_tmo === 1'b1)   begin tmo_cnt++; tmo_cyc = cyc; end
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_tmo",   32'(frame_tmo),   32'(m_tmo));
    check("hexs",        32'(hexs),        32'(m_hexs));
    check("points",      32'(points),      32'(m_points));
    check("LEs",         32'(LEs),         32'(m_les));
    check("decode_err",  32'(decode_err),  32'(m_err));
  endtask

  task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int len);
    last_start = cyc + 1;
    last_key = {an, seg};
    for (int i = 0; i < len; i++)
      step(an, seg, (i == ACC_AT) && (dig(an) >= 0) && (len >= MIN_ACC));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    last_key = 12'hFFF;
  endtask

  task automatic frame_abcd();
    dwell(4'hE, 8'h21, 8);
    dwell(4'hD, 8'h46, 8);
    dwell(4'hB, 8'h03, 8);
    dwell(4'h7, 8'h08, 8);
  endtask

  initial begin
    int f0, t0, c0;
    logic [3:0] an;
    logic [7:0] seg;
    int len, r;

    // Reset values
    do_reset(3);
    check("rst_hexs", 32'(hexs), 32'h0);
    check("rst_LEs", 32'(LEs), 32'hF);
    check("rst_err", 32'(decode_err), 32'h0);

    // 1: basic frame d,C,b,A and commit latency
    f0 = fv_cnt;
    frame_abcd();
    check("t1_frames", 32'(fv_cnt - f0), 32'd1);
    check("t1_latency", 32'(fv_cyc - last_start), 32'd7);
    check("t1_hexs", 32'(hexs), 32'hABCD);
    check("t1_LEs", 32'(LEs), 32'h0);
    check("t1_points", 32'(points), 32'h0);

    // 2: point on digit1, blank digit2
    dwell(4'hE, 8'h40, 8);
    dwell(4'hD, 8'hC0, 8);
    dwell(4'hB, 8'h7F, 8);
    dwell(4'h7, 8'h08, 8);
    check("t2_hexs", 32'(hexs), 32'hA000);
    check("t2_points", 32'(points), 32'b0010);
    check("t2_LEs", 32'(LEs), 32'b0100);

    // 3: short '1' glitch ahead of a real '0' on digit0
    dwell(4'hE, 8'h79, 3);
    dwell(4'hE, 8'h40, 8);
    dwell(4'hD, 8'h46, 8);
    dwell(4'hB, 8'h03, 8);
    dwell(4'h7, 8'h08, 8);
    check("t3_hexs", 32'(hexs), 32'hABC0);

    // 4: idle and multi-select gaps between digits
    f0 = fv_cnt;
    dwell(4'hE, 8'h21, 8);
    dwell(4'hF, 8'hFF, 20);
    dwell(4'hD, 8'h46, 8);
    dwell(4'hC, 8'h21, 20);
    dwell(4'hB, 8'h03, 8);
    dwell(4'h7, 8'h08, 8);
    check("t4_frames", 32'(fv_cnt - f0), 32'd1);
    check("t4_hexs", 32'(hexs), 32'hABCD);
    check("t4_err", 32'(decode_err), 32'h0);

    // 5: undecodable digit2, sticky across a later good frame
    dwell(4'hE, 8'h21, 8);
    dwell(4'hD, 8'h46, 8);
    dwell(4'hB, 8'h55, 8);
    dwell(4'h7, 8'h08, 8);
    check("t5_err", 32'(decode_err), 32'b0100);
    check("t5_hexs", 32'(hexs), 32'hA0CD);
    frame_abcd();
    check("t5_err_sticky", 32'(decode_err), 32'b0100);
    check("t5_hexs_good", 32'(hexs), 32'hABCD);

    // Random dwells, glitches and invalid selects
    for (int k = 0; k < 180; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        an = 4'hF;
        an[$urandom_range(0, 3)] = 1'b0;
        case ($urandom_range(0, 9))
          7:       seg = {1'($urandom), 7'h7F};
          8, 9:    seg = 8'($urandom);
          default: seg = {1'($urandom), SEG_TBL[$urandom_range(0, 15)]};
        endcase
        len = (r < 6) ? $urandom_range(MIN_ACC, MIN_ACC + 3) : $urandom_range(1, STABLE - 1);
      end else begin
        do an = 4'($urandom); while (dig(an) >= 0);
        seg = 8'($urandom);
        len = $urandom_range(1, 20);
      end
      if ({an, seg} == last_key) seg = seg ^ 8'h80;
      dwell(an, seg, len);
    end

    // 6: partial frame, timeout (or indefinite wait), then reset mid-dwell
    do_reset(2);
    f0 = fv_cnt;
    t0 = tmo_cnt;
    dwell(4'hE, 8'h21, 8);
    c0 = last_start;
    dwell(4'hD, 8'h46, 8);
    dwell(4'hF, 8'hFF, 100);
    check("t6_no_frame", 32'(fv_cnt - f0), 32'd0);
`ifdef SEG_SCAN_TIMEOUT_EN
    check("t6_tmo_count", 32'(tmo_cnt - t0), 32'd1);
    check("t6_tmo_cycle", 32'(tmo_cyc - c0), 32'(ACC_AT + TIMEOUT));
`else
    check("t6_tmo_count", 32'(tmo_cnt - t0), 32'd0);
    check("t6_first_start", 32'(c0 + 116), 32'(cyc + 1));
    dwell(4'hB, 8'h03, 8);
    dwell(4'h7, 8'h08, 8);
    check("t6_late_frame", 32'(fv_cnt - f0), 32'd1);
    check("t6_late_hexs", 32'(hexs), 32'hABCD);
`endif
    dwell(4'hB, 8'h03, 3);
    rst = 1'b1;
    step(4'hB, 8'h03, 1'b0);
    rst = 1'b0;
    last_key = 12'hB03;
    check("t6_rst_hexs", 32'(hexs), 32'h0);
    check("t6_rst_points", 32'(points), 32'h0);
    check("t6_rst_LEs", 32'(LEs), 32'hF);
    check("t6_rst_err", 32'(decode_err), 32'h0);
    check("t6_rst_fv", 32'(frame_valid), 32'h0);

    // After reset, three digits are not enough; the fourth commits
    f0 = fv_cnt;
    dwell(4'hF, 8'hFF, 4);
    dwell(4'hE, 8'h21, 8);
    dwell(4'hD, 8'h46, 8);
    dwell(4'hB, 8'h03, 8);
    check("t7_partial", 32'(fv_cnt - f0), 32'd0);
    dwell(4'h7, 8'h08, 8);
    check("t7_frames", 32'(fv_cnt - f0), 32'd1);
    check("t7_hexs", 32'(hexs), 32'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
